// File: rtl/i2c_bridge_pkg.sv
// -----------------------------------------------------------------------------
// i2c_bridge_pkg
// Shared definitions for the I2C register bridge:
//   - bridge_state_e     : bus-access state encoding (IDLE, WRITE, READ)
//   - TIMEOUT_CYCLES_DEF : default bus_ack wait budget in clk cycles
//   - DEFAULT_RDATA_DEF  : default read data returned when a read times out
//   - sat_add8()         : saturating add used by the error counter
// -----------------------------------------------------------------------------
package i2c_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } bridge_state_e;

  localparam int          TIMEOUT_CYCLES_DEF = 255;
  localparam logic [15:0] DEFAULT_RDATA_DEF  = 16'hDEAD;

  // Adds 0..3 to an 8-bit count, sticking at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] value,
                                          input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, value} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/i2c_bus_timeout.sv
// -----------------------------------------------------------------------------
// i2c_bus_timeout
// Cycle counter bounding one bus access. Reused by the write and read paths.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   load       : clears the count (asserted on the edge that starts an access)
//   run        : access still waiting this cycle (bus_req high, no bus_ack)
//   expired    : count has reached TIMEOUT_CYCLES-1; the caller qualifies it
//                with bus_req, so the access lasts exactly TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------
module i2c_bus_timeout
  import i2c_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // The count holds at LAST so it can never wrap back into the live range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/i2c_reg_bridge.sv
// -----------------------------------------------------------------------------
// i2c_reg_bridge
// Turns the I2C slave's register interface into a request/acknowledge register
// bus. Writes go through a 1-deep buffer; reads are prefetched for the slave's
// current register address so slv_datai is already stable when sampled.
// Every bus access is bounded by a timeout; timeouts and dropped writes are
// counted in a saturating error counter.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   slv_we        : one-cycle write strobe from the slave
//   slv_datao     : write data from the slave (valid with slv_we)
//   slv_reg_addr  : current register address from the slave
//   slv_done      : end-of-transaction pulse; forces a refetch
//   slv_datai     : registered read data to the slave
//   bus_req       : request, held until bus_ack or timeout
//   bus_wr        : 1 = write, 0 = read (stable while bus_req)
//   bus_addr      : access address (stable while bus_req)
//   bus_wdata     : write data (stable while bus_req)
//   bus_ack       : one-cycle completion from the target
//   bus_rdata     : read data, valid with bus_ack on a read
//   err_count     : saturating count of timeouts plus dropped writes
//   wr_overflow   : sticky flag, a write was dropped
// -----------------------------------------------------------------------------
module i2c_reg_bridge
  import i2c_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA  = DATA_WIDTH'(DEFAULT_RDATA_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slv_we,
  input  logic [DATA_WIDTH-1:0] slv_datao,
  input  logic [ADDR_WIDTH-1:0] slv_reg_addr,
  input  logic                  slv_done,
  output logic [DATA_WIDTH-1:0] slv_datai,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [7:0]            err_count,
  output logic                  wr_overflow
);

  bridge_state_e         state;

  // Write buffer: wbuf_full stays set while its write is on the bus and is
  // released only when that write acks or times out.
  logic                  wbuf_full;
  logic [ADDR_WIDTH-1:0] wbuf_addr;
  logic [DATA_WIDTH-1:0] wbuf_data;

  // Address of the last prefetch, i.e. what slv_datai currently holds.
  logic                  tag_valid;
  logic [ADDR_WIDTH-1:0] tag;

  logic                  expired;
  logic                  acked;
  logic                  timed_out;
  logic                  finish;
  logic                  wbuf_free;
  logic                  overflow;
  logic                  wbuf_take;
  logic                  wbuf_full_nx;
  logic [ADDR_WIDTH-1:0] wbuf_addr_nx;
  logic [DATA_WIDTH-1:0] wbuf_data_nx;
  logic                  prefetch_need;
  logic                  launch;
  logic [1:0]            err_inc;

  // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
  always_comb begin
    acked         = bus_req & bus_ack;
    // An ack in the expiry cycle wins: that access completes without error.
    timed_out     = bus_req & ~bus_ack & expired;
    finish        = acked | timed_out;
    // A write finishing this cycle frees the buffer for a same-cycle slv_we.
    wbuf_free     = (state == WRITE) & finish;
    overflow      = slv_we & wbuf_full & ~wbuf_free;
    wbuf_take     = slv_we & ~overflow;
    wbuf_full_nx  = wbuf_take | (wbuf_full & ~wbuf_free);
    wbuf_addr_nx  = wbuf_take ? slv_reg_addr : wbuf_addr;
    wbuf_data_nx  = wbuf_take ? slv_datao    : wbuf_data;
    prefetch_need = ~tag_valid | (tag != slv_reg_addr);
    // Using the post-capture buffer lets a strobe seen in IDLE reach the bus
    // on the very next cycle.
    launch        = (state == IDLE) & (wbuf_full_nx | prefetch_need);
    err_inc       = {1'b0, timed_out} + {1'b0, overflow};
  end

  i2c_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (launch),
    .run     (bus_req & ~bus_ack),
    .expired (expired)
  );

  // NOTE: non-blocking assignments throughout; the slv_done clear sits last so it overrides a same-cycle read completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      slv_datai   <= '0;
      bus_req     <= 1'b0;
      bus_wr      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      err_count   <= '0;
      wr_overflow <= 1'b0;
      wbuf_full   <= 1'b0;
      wbuf_addr   <= '0;
      wbuf_data   <= '0;
      tag_valid   <= 1'b0;
      tag         <= '0;
    end else begin
      wbuf_full <= wbuf_full_nx;
      wbuf_addr <= wbuf_addr_nx;
      wbuf_data <= wbuf_data_nx;
      err_count <= sat_add8(err_count, err_inc);
      if (overflow) begin
        wr_overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (wbuf_full_nx) begin
            state     <= WRITE;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b1;
            bus_addr  <= wbuf_addr_nx;
            bus_wdata <= wbuf_data_nx;
          end else if (prefetch_need) begin
            state    <= READ;
            bus_req  <= 1'b1;
            bus_wr   <= 1'b0;
            bus_addr <= slv_reg_addr;
          end
        end

        WRITE: begin
          if (finish) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            // The prefetched copy of this register is now stale.
            if (tag == bus_addr) begin
              tag_valid <= 1'b0;
            end
          end
        end

        READ: begin
          if (finish) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            slv_datai <= acked ? bus_rdata : DEFAULT_RDATA;
            tag       <= bus_addr;
            tag_valid <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase

      if (slv_done) begin
        tag_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_bridge
// Self-checking bench for i2c_reg_bridge (TIMEOUT_CYCLES = 4). A transaction-
// level model of the bridge is advanced on every clock edge and compared with
// the DUT outputs on every falling edge. Directed scenarios pin known values;
// a randomized phase drives strobes, address changes, done pulses, ack delays
// and spurious acks.
// -----------------------------------------------------------------------------
module tb_i2c_reg_bridge;

  localparam int          TMO   = 4;
  localparam logic [15:0] DEAD  = 16'hDEAD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        slv_we = 1'b0;
  logic [15:0] slv_datao = '0;
  logic [7:0]  slv_reg_addr = 8'h10;
  logic        slv_done = 1'b0;
  logic [15:0] slv_datai;
  logic        bus_req;
  logic        bus_wr;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;
  logic [7:0]  err_count;
  logic        wr_overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  i2c_reg_bridge #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (16),
    .TIMEOUT_CYCLES (TMO),
    .DEFAULT_RDATA  (DEAD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .slv_we       (slv_we),
    .slv_datao    (slv_datao),
    .slv_reg_addr (slv_reg_addr),
    .slv_done     (slv_done),
    .slv_datai    (slv_datai),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .err_count    (err_count),
    .wr_overflow  (wr_overflow)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("FAIL %s: actual=%h expected=%h at t=%0t", name, actual, expected, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one pending-write slot, one outstanding access with an
  // age in cycles, and the address/data of the last prefetch.
  // ---------------------------------------------------------------------------
  logic        m_req = 1'b0;
  logic        m_wr = 1'b0;
  logic [7:0]  m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_datai = '0;
  int          m_err = 0;
  logic        m_ovf = 1'b0;
  int          m_age = 0;
  logic        m_wb_full = 1'b0;
  logic [7:0]  m_wb_addr = '0;
  logic [15:0] m_wb_data = '0;
  logic        m_tag_valid = 1'b0;
  logic [7:0]  m_tag = '0;
  logic        mdl_ack, mdl_tmo, mdl_fin, mdl_need, mdl_ovf_now;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_req = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_datai = '0;
      m_err = 0; m_ovf = 1'b0; m_age = 0; m_wb_full = 1'b0;
      m_tag_valid = 1'b0; m_tag = '0;
    end else begin
      mdl_ack  = m_req && bus_ack;
      mdl_tmo  = m_req && !bus_ack && (m_age == TMO - 1);
      mdl_fin  = mdl_ack || mdl_tmo;
      mdl_need = !m_tag_valid || (m_tag != slv_reg_addr);
      // Slot is released by a finishing write before this cycle's strobe lands.
      if (m_req && m_wr && mdl_fin) m_wb_full = 1'b0;
      mdl_ovf_now = 1'b0;
      if (slv_we) begin
        if (m_wb_full) mdl_ovf_now = 1'b1;
        else begin
          m_wb_full = 1'b1; m_wb_addr = slv_reg_addr; m_wb_data = slv_datao;
        end
      end
      if (m_req) begin
        if (mdl_fin) begin
          if (m_wr) begin
            if (m_addr == m_tag) m_tag_valid = 1'b0;
          end else begin
            m_datai = mdl_ack ? bus_rdata : DEAD;
            m_tag = m_addr; m_tag_valid = 1'b1;
          end
          m_req = 1'b0;
        end else begin
          m_age++;
        end
      end else if (m_wb_full) begin
        m_req = 1'b1; m_wr = 1'b1; m_addr = m_wb_addr; m_wdata = m_wb_data; m_age = 0;
      end else if (mdl_need) begin
        m_req = 1'b1; m_wr = 1'b0; m_addr = slv_reg_addr; m_age = 0;
      end
      if (slv_done) m_tag_valid = 1'b0;
      m_err = m_err + int'(mdl_tmo) + int'(mdl_ovf_now);
      if (m_err > 255) m_err = 255;
      if (mdl_ovf_now) m_ovf = 1'b1;
    end
  end

  // Compare process: every falling edge once the bench has started.
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("slv_datai", slv_datai, m_datai);
      check("bus_req", bus_req, m_req);
      check("err_count", err_count, m_err);
      check("wr_overflow", wr_overflow, m_ovf);
      if (m_req) begin
        check("bus_wr", bus_wr, m_wr);
        check("bus_addr", bus_addr, m_addr);
        if (m_wr) check("bus_wdata", bus_wdata, m_wdata);
      end
    end
  end

  // Bus monitor: logs write data of each access start and counts busy cycles.
  logic [15:0] wr_log[$];
  int          req_high_cycles = 0;
  logic        prev_req = 1'b0;
  always @(negedge clk) begin
    if (bus_req && !prev_req && bus_wr) wr_log.push_back(bus_wdata);
    if (bus_req) req_high_cycles++;
    prev_req = bus_req;
  end

  // Bus target: acks after a programmable number of waiting cycles.
  bit          tgt_random = 1'b0;
  bit          tgt_never  = 1'b0;
  int          tgt_delay  = 3;
  logic [15:0] tgt_rdata  = 16'h1234;
  int          req_cycles = 0;
  int          delay_cur  = 0;
  bit          never_cur  = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset || !bus_req) begin
        req_cycles = 0;
        bus_ack    = tgt_random && ($urandom_range(0, 7) == 0);
        bus_rdata  = 16'($urandom);
      end else begin
        req_cycles++;
        if (req_cycles == 1) begin
          if (tgt_random) begin
            delay_cur = int'($urandom_range(0, 7));
            never_cur = (delay_cur > 5);
          end else begin
            delay_cur = tgt_delay;
            never_cur = tgt_never;
          end
        end
        bus_ack   = !never_cur && (req_cycles == delay_cur + 1);
        bus_rdata = tgt_random ? 16'($urandom) : tgt_rdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus_req) begin ok = 1'b1; break; end
    end
    check("req_seen", ok, 1);
  endtask

  task automatic wait_ack(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_req && bus_ack) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("ack_seen", ok, 1);
  endtask

  task automatic wait_idle(input int n, input int budget);
    bit ok = 1'b0;
    int run = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      run = bus_req ? 0 : run + 1;
      if (run >= n) begin ok = 1'b1; break; end
    end
    check("idle_reached", ok, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    // Reset state.
    repeat (3) step();
    @(negedge clk);
    check("rst_slv_datai", slv_datai, 16'h0000);
    check("rst_bus_req", bus_req, 0);
    check("rst_err_count", err_count, 8'h00);
    check("rst_wr_overflow", wr_overflow, 0);
    cmp_en = 1'b1;
    step();
    reset = 1'b0;

    // Prefetch of 8'h10, target acks after 3 waiting cycles with 16'h1234.
    wait_req(10);
    check("s1_bus_addr", bus_addr, 8'h10);
    check("s1_bus_wr", bus_wr, 0);
    wait_ack(10);
    @(negedge clk);
    check("s1_slv_datai", slv_datai, 16'h1234);
    check("s1_model_datai", m_datai, 16'h1234);
    snap = req_high_cycles;
    repeat (10) @(negedge clk);
    check("s1_no_more_req", req_high_cycles - snap, 0);

    // Write 16'hBEEF to 8'h10, then the invalidated tag forces a re-read.
    tgt_delay = 2;
    tgt_rdata = 16'h5678;
    step();
    slv_we = 1'b1; slv_datao = 16'hBEEF;
    step();
    slv_we = 1'b0;
    @(negedge clk);
    check("s2_req_latency", bus_req, 1);
    check("s2_bus_wr", bus_wr, 1);
    check("s2_bus_addr", bus_addr, 8'h10);
    check("s2_bus_wdata", bus_wdata, 16'hBEEF);
    wait_ack(10);
    wait_req(10);
    check("s2_reread_wr", bus_wr, 0);
    check("s2_reread_addr", bus_addr, 8'h10);
    wait_ack(10);
    @(negedge clk);
    check("s2_reread_data", slv_datai, 16'h5678);

    // Second strobe while the first write is still waiting: dropped.
    wait_idle(3, 50);
    wr_log.delete();
    step(); slv_we = 1'b1; slv_datao = 16'hBEEF;
    step(); slv_we = 1'b0;
    step(); slv_we = 1'b1; slv_datao = 16'h1111;
    step(); slv_we = 1'b0;
    wait_idle(3, 50);
    check("s3_write_count", wr_log.size(), 1);
    if (wr_log.size() > 0) check("s3_write_data", wr_log[0], 16'hBEEF);
    check("s3_wr_overflow", wr_overflow, 1);
    check("s3_err_count", err_count, 8'd1);

    // Read that is never acked: exactly TMO busy cycles, default data.
    tgt_never = 1'b1;
    step();
    slv_reg_addr = 8'h33;
    snap = req_high_cycles;
    repeat (12) @(negedge clk);
    check("s4_req_cycles", req_high_cycles - snap, 4);
    check("s4_slv_datai", slv_datai, 16'hDEAD);
    check("s4_err_count", err_count, 8'd2);
    check("s4_model_err", m_err, 2);

    // 300 more timeouts: the counter saturates.
    for (int i = 0; i < 300; i++) begin
      step();
      slv_reg_addr = (i % 2 == 1) ? 8'h41 : 8'h40;
      repeat (6) step();
    end
    @(negedge clk);
    check("s5_err_sat", err_count, 8'hFF);
    check("s5_wr_overflow", wr_overflow, 1);

    // Reset pulse while a write is waiting on the bus.
    step();
    slv_reg_addr = 8'h50; slv_we = 1'b1; slv_datao = 16'hAAAA;
    step();
    slv_we = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("s6_bus_req", bus_req, 0);
    check("s6_wbuf_full", dut.wbuf_full, 0);
    check("s6_err_count", err_count, 8'h00);
    check("s6_wr_overflow", wr_overflow, 0);
    check("s6_slv_datai", slv_datai, 16'h0000);
    step();
    reset = 1'b0;
    wr_log.delete();
    repeat (12) @(negedge clk);
    check("s6_no_replay", wr_log.size(), 0);

    // Randomized traffic.
    tgt_never  = 1'b0;
    tgt_random = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      step();
      slv_we    = ($urandom_range(0, 7) == 0);
      slv_datao = 16'($urandom);
      slv_done  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) slv_reg_addr = 8'h10 + 8'($urandom_range(0, 3));
    end
    step();
    slv_we = 1'b0; slv_done = 1'b0;
    tgt_random = 1'b0; tgt_delay = 1;
    wait_idle(3, 200);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
